dmem_arbiter: RTL and testbench

Two-master arbiter and sequencer for the single-port data memory. It accepts word-indexed read/write requests from master 0 (CPU MEM stage) and master 1 (debug/loader port), grants one at a time, and drives the memory's write-enable, read-enable, address and write-data inputs. It returns registered read data with a one-cycle acknowledge. It sits between the pipeline's MEM stage and the data memory.

---
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the single-port data memory: IDLE -> SERVE -> ACK.
// Define DMEM_ARB_RR_EN for round-robin tie-break; otherwise m0 has fixed priority.
module dmem_arbiter #(
  parameter int DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_rdata_o,
  output logic        m1_ack_o,
  output logic [31:0] m1_rdata_o,
  output logic        err_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  grant_o
);
  typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state, state_nxt;
  logic [1:0]  win, grant_q;
  logic        hold_we, err_q, in_range;
  logic [31:0] hold_addr, hold_wdata, rdata_q;

  assign in_range = hold_addr < DEPTH_W;
  assign grant_o  = grant_q;

`ifdef DMEM_ARB_RR_EN
  logic last_m1;

  // On a tie, the master not granted most recently wins
  always_comb begin
    win = 2'b00;
    if (m0_req_i && m1_req_i) win = last_m1 ? 2'b01 : 2'b10;
    else if (m0_req_i)        win = 2'b01;
    else if (m1_req_i)        win = 2'b10;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)                        last_m1 <= 1'b1;
    else if (state == IDLE && |win)    last_m1 <= win[1];
  end
`else
  assign win = m0_req_i ? 2'b01 : {m1_req_i, 1'b0};
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    m0_ack_o    = 1'b0;
    m1_ack_o    = 1'b0;
    err_o       = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    unique case (state)
      IDLE: if (m0_req_i || m1_req_i) state_nxt = SERVE;
      SERVE: begin
        state_nxt   = ACK;
        // rst_i gate keeps a write from landing on the reset edge
        mem_we_o    = hold_we & in_range & rst_i;
        mem_re_o    = ~hold_we & in_range;
        mem_addr_o  = hold_addr;
        mem_wdata_o = hold_wdata;
      end
      ACK: begin
        state_nxt  = IDLE;
        m0_ack_o   = grant_q[0];
        m1_ack_o   = grant_q[1];
        err_o      = err_q;
        m0_rdata_o = grant_q[0] ? rdata_q : '0;
        m1_rdata_o = grant_q[1] ? rdata_q : '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      grant_q    <= 2'b00;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (|win) begin
          grant_q    <= win;
          hold_we    <= win[0] ? m0_we_i    : m1_we_i;
          hold_addr  <= win[0] ? m0_addr_i  : m1_addr_i;
          hold_wdata <= win[0] ? m0_wdata_i : m1_wdata_i;
        end
        SERVE: begin
          rdata_q <= (!hold_we && in_range) ? mem_rdata_i : '0;
          err_q   <= ~in_range;
        end
        ACK:     grant_q <= 2'b00;
        default: grant_q <= 2'b00;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level model predicts serve order and data,
// a negedge monitor pops expectations on every ack.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        req[2];
  logic        we_d[2];
  logic [31:0] addr_d[2];
  logic [31:0] wd_d[2];
  logic        m0_ack_o, m1_ack_o, err_o, mem_we_o, mem_re_o;
  logic [31:0] m0_rdata_o, m1_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [1:0]  grant_o;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(req[0]), .m0_we_i(we_d[0]), .m0_addr_i(addr_d[0]), .m0_wdata_i(wd_d[0]),
    .m1_req_i(req[1]), .m1_we_i(we_d[1]), .m1_addr_i(addr_d[1]), .m1_wdata_i(wd_d[1]),
    .m0_ack_o(m0_ack_o), .m0_rdata_o(m0_rdata_o),
    .m1_ack_o(m1_ack_o), .m1_rdata_o(m1_rdata_o),
    .err_o(err_o), .mem_we_o(mem_we_o), .mem_re_o(mem_re_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .grant_o(grant_o)
  );

  typedef struct {int m; logic err; logic [31:0] rdata; int cyc;} exp_t;
  exp_t expq[$];

  int tests = 0, fails = 0, cyc = 0, wr_cnt = 0, exp_wr = 0;
  bit started = 1'b0;
  logic [31:0] ram[32];
  logic [31:0] model_mem[32];
  bit pend[2];
  int last = 1;

  function automatic logic [31:0] pat(int i);
    return 32'h0A5A_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  // Memory harness: combinational read, write on rising edge
  assign mem_rdata_i = ram[mem_addr_o[4:0]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!started) for (int i = 0; i < 32; i++) ram[i] = pat(i);
    else if (mem_we_o) begin
      ram[mem_addr_o[4:0]] = mem_wdata_o;
      wr_cnt++;
    end
  end

  always @(negedge clk) if (started) begin
    if (m0_ack_o || m1_ack_o) begin
      if (expq.size() == 0) chk("unexpected_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
      else begin
        exp_t e;
        e = expq.pop_front();
        chk("ack_master", {30'd0, m1_ack_o, m0_ack_o}, (e.m == 0) ? 32'd1 : 32'd2);
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_err", {31'd0, err_o}, {31'd0, e.err});
        chk("ack_rdata", (e.m == 0) ? m0_rdata_o : m1_rdata_o, e.rdata);
        chk("nonowner_rdata", (e.m == 0) ? m1_rdata_o : m0_rdata_o, 32'd0);
        chk("ack_grant", {30'd0, grant_o}, (e.m == 0) ? 32'd1 : 32'd2);
      end
    end else begin
      chk("idle_err", {31'd0, err_o}, 32'd0);
      chk("idle_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
    end
  end

  task automatic set_req(int m, logic we, logic [31:0] a, logic [31:0] d);
    pend[m] = 1'b1;
    req[m] = 1'b1; we_d[m] = we; addr_d[m] = a; wd_d[m] = d;
  endtask

  // One arbitration slot: model picks the winner from the rules, predicts the ack,
  // then walks the DUT through SERVE and ACK.
  task automatic step();
    int w;
    exp_t e;
    bit glitch;
    if (!pend[0] && !pend[1]) begin
      @(posedge clk); @(negedge clk);
      return;
    end
    if (pend[0] && pend[1]) begin
`ifdef DMEM_ARB_RR_EN
      w = (last == 1) ? 0 : 1;
`else
      w = 0;
`endif
    end else w = pend[0] ? 0 : 1;
    last = w;
    e.m = w;
    e.cyc = cyc + 2;
    e.err = (addr_d[w] >= 32);
    e.rdata = 32'd0;
    if (!e.err) begin
      if (we_d[w]) begin
        model_mem[addr_d[w][4:0]] = wd_d[w];
        exp_wr++;
      end else e.rdata = model_mem[addr_d[w][4:0]];
    end
    expq.push_back(e);
    @(posedge clk); @(negedge clk);
    // A request raised and dropped while busy must be ignored
    glitch = !pend[1-w] && ($urandom_range(0, 2) == 0);
    if (glitch) begin
      req[1-w] = 1'b1; we_d[1-w] = 1'b1; addr_d[1-w] = 32'd9; wd_d[1-w] = $urandom;
    end
    @(posedge clk); @(negedge clk);
    if (glitch) req[1-w] = 1'b0;
    @(posedge clk); @(negedge clk);
    pend[w] = 1'b0;
    req[w] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; we_d[m] = 1'b0; addr_d[m] = '0; wd_d[m] = '0; pend[m] = 1'b0;
    end
    for (int i = 0; i < 32; i++) model_mem[i] = pat(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", {30'd0, grant_o}, 32'd0);
    chk("rst_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_rdata", m0_rdata_o | m1_rdata_o, 32'd0);
    chk("rst_mem", {30'd0, mem_we_o, mem_re_o} | mem_addr_o | mem_wdata_o, 32'd0);
    rst_i = 1'b1;
    started = 1'b1;

    // Write then read back on m0
    set_req(0, 1'b1, 32'd5, 32'hDEADBEEF); step();
    set_req(0, 1'b0, 32'd5, 32'd0);        step();
    // Ties, twice
    for (int k = 0; k < 2; k++) begin
      set_req(0, 1'b0, 32'd3, 32'd0);
      set_req(1, 1'b1, 32'd3, 32'h11 + 32'(k));
      step(); step();
    end
    // m0 continuous load while m1 holds its request
    set_req(1, 1'b0, 32'd3, 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (!pend[0]) set_req(0, 1'b1, 32'(10 + k), $urandom);
      step();
    end
    while (pend[0] || pend[1]) step();
    // Out-of-range write, then read of addr 0
    set_req(1, 1'b1, 32'd32, 32'h1234); step();
    set_req(0, 1'b0, 32'd0, 32'd0);     step();
    set_req(0, 1'b0, 32'd31, 32'd0);    step();

    // Reset during SERVE of an m0 write
    set_req(0, 1'b1, 32'd7, 32'hCAFEF00D);
    @(posedge clk); @(negedge clk);
    chk("serve_grant", {30'd0, grant_o}, 32'd1);
    chk("serve_addr", mem_addr_o, 32'd7);
    rst_i = 1'b0; req[0] = 1'b0; pend[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst2_grant", {30'd0, grant_o}, 32'd0);
    chk("rst2_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    chk("rst2_mem", {30'd0, mem_we_o, mem_re_o} | mem_addr_o | mem_wdata_o, 32'd0);
    chk("rst2_no_write", ram[7], model_mem[7]);
    rst_i = 1'b1;
    last = 1;
    set_req(0, 1'b0, 32'd7, 32'd0); step();

    // Randomized traffic
    for (int s = 0; s < 80; s++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 2) != 0)
          set_req(m, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 32'd32 + 32'($urandom_range(0, 1000)) : 32'($urandom_range(0, 31)),
                  $urandom);
      step();
    end
    while (pend[0] || pend[1]) step();

    repeat (5) @(negedge clk);
    chk("queue_empty", expq.size(), 32'd0);
    chk("write_count", wr_cnt, exp_wr);
    for (int i = 0; i < 32; i++) chk("final_mem", ram[i], model_mem[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
